// File: rtl/qspi_psram_ctrl_if.sv
// rtl/qspi_psram_ctrl_if.sv - memory-bus request/response bundle for qspi_psram_ctrl
//
// Signals (directions seen from the controller):
//   req_i   in   request valid, taken on a rising edge where req_i & rdy_o
//   rdy_o   out  controller idle and unlocked
//   we_i    in   1 = write, 0 = read
//   adr_i   in   24-bit PSRAM byte address
//   size_i  in   0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   wdat_i  in   write data, little-endian
//   rdat_o  out  read data, little-endian, unused upper bytes zero
//   ack_o   out  one-cycle completion pulse
interface qspi_psram_ctrl_if;
  logic        req_i;
  logic        rdy_o;
  logic        we_i;
  logic [23:0] adr_i;
  logic [1:0]  size_i;
  logic [31:0] wdat_i;
  logic [31:0] rdat_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, adr_i, size_i, wdat_i,
    input  rdy_o, rdat_o, ack_o
  );

  modport slave (
    input  req_i, we_i, adr_i, size_i, wdat_i,
    output rdy_o, rdat_o, ack_o
  );
endinterface

// File: rtl/qspi_psram_ctrl.sv
// rtl/qspi_psram_ctrl.sv - host-side QSPI PSRAM controller (quad enable, quad write, quad fast read)
//
// Ports:
//   clk_i        in   system clock
//   rst_in       in   asynchronous active-low reset
//   bus          slave modport of qspi_psram_ctrl_if (req/rdy/we/adr/size/wdat/rdat/ack)
//   init_done_o  out  quad-mode unlock sequence completed
//   sck_o        out  serial clock, clk_i/2 while active, low in IDLE
//   cs_on        out  active-low chip select
//   sd_o         out  io3..io0 output data
//   sd_oe_o      out  io3..io0 output enables
//   sd_i         in   io3..io0 input data
module qspi_psram_ctrl #(
  parameter int DUMMY_CYCLES = 6,
  parameter int CS_GAP       = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  qspi_psram_ctrl_if.slave        bus,
  output logic                    init_done_o,
  output logic                    sck_o,
  output logic                    cs_on,
  output logic [3:0]              sd_o,
  output logic [3:0]              sd_oe_o,
  input  logic [3:0]              sd_i
);

  typedef enum logic [2:0] {
    UNLOCK,
    IDLE,
    CMD,
    ADR,
    DUMMY,
    WDATA,
    RDATA,
    GAP
  } state_t;

  localparam logic [7:0] UNLOCK_CMD = 8'h35;
  localparam logic [7:0] WRITE_CMD  = 8'h38;
  localparam logic [7:0] READ_CMD   = 8'hEB;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;   // 0: next edge is phase L, 1: next edge is phase H
  logic [7:0]  cnt_q, cnt_d;       // SPI cycle index within the current state
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic [3:0]  sd_q, sd_d;
  logic [3:0]  sd_oe_q, sd_oe_d;
  logic        rdy_q, rdy_d;
  logic        ack_q, ack_d;
  logic        init_done_q, init_done_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        we_q, we_d;
  logic [23:0] adr_q, adr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdat_q, wdat_d;
  logic        xact_q, xact_d;     // GAP follows a bus transaction (not the unlock)

  logic        accept;
  logic [2:0]  bit_idx;
  logic [2:0]  adr_nib;
  logic [2:0]  dat_nib;
  logic [7:0]  cmd_byte;
  logic [7:0]  data_last;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    sd_d        = sd_q;
    sd_oe_d     = sd_oe_q;
    rdy_d       = rdy_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    rdat_d      = rdat_q;
    rbuf_d      = rbuf_q;
    we_d        = we_q;
    adr_d       = adr_q;
    size_d      = size_q;
    wdat_d      = wdat_q;
    xact_d      = xact_q;

    accept    = bus.req_i & rdy_q;
    bit_idx   = 3'd7 - cnt_q[2:0];
    adr_nib   = 3'd5 - cnt_q[2:0];
    // Byte k goes out high nibble first: cycle 2k -> nibble 2k+1, cycle 2k+1 -> nibble 2k.
    dat_nib   = {cnt_q[2:1], ~cnt_q[0]};
    cmd_byte  = we_q ? WRITE_CMD : READ_CMD;
    data_last = (size_q == 2'd0) ? 8'd1 : (size_q == 2'd1) ? 8'd3 : 8'd7;

    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        if (accept) begin
          rdy_d   = 1'b0;
          state_d = CMD;
          phase_d = 1'b0;
          cnt_d   = 8'd0;
          we_d    = bus.we_i;
          adr_d   = bus.adr_i;
          size_d  = bus.size_i;
          wdat_d  = bus.wdat_i;
          rbuf_d  = 32'd0;
          xact_d  = 1'b1;
        end
      end
      default: begin
        if (!phase_q) begin
          // Phase L: SCK falls, pins change.
          sck_d   = 1'b0;
          phase_d = 1'b1;
          case (state_q)
            UNLOCK: begin
              cs_n_d  = 1'b0;
              sd_oe_d = 4'b0001;
              sd_d    = {3'b000, UNLOCK_CMD[bit_idx]};
            end
            CMD: begin
              cs_n_d  = 1'b0;
              sd_oe_d = 4'b0001;
              sd_d    = {3'b000, cmd_byte[bit_idx]};
            end
            ADR: begin
              cs_n_d  = 1'b0;
              sd_oe_d = 4'b1111;
              sd_d    = adr_q[{adr_nib, 2'b00} +: 4];
            end
            WDATA: begin
              cs_n_d  = 1'b0;
              sd_oe_d = 4'b1111;
              sd_d    = wdat_q[{dat_nib, 2'b00} +: 4];
            end
            DUMMY, RDATA: begin
              cs_n_d  = 1'b0;
              sd_oe_d = 4'b0000;
              sd_d    = 4'b0000;
            end
            default: begin
              // GAP: the first L edge also closes the transaction.
              cs_n_d  = 1'b1;
              sd_oe_d = 4'b0000;
              sd_d    = 4'b0000;
              if (cnt_q == 8'd0 && xact_q) begin
                ack_d  = 1'b1;
                xact_d = 1'b0;
                if (!we_q) begin
                  rdat_d = rbuf_q;
                end
              end
            end
          endcase
        end else begin
          // Phase H: SCK rises, sd_i sampled on this edge.
          sck_d   = 1'b1;
          phase_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          case (state_q)
            UNLOCK: begin
              if (cnt_q == 8'd7) begin
                state_d = GAP;
                cnt_d   = 8'd0;
              end
            end
            CMD: begin
              if (cnt_q == 8'd7) begin
                state_d = ADR;
                cnt_d   = 8'd0;
              end
            end
            ADR: begin
              if (cnt_q == 8'd5) begin
                cnt_d = 8'd0;
                if (we_q) begin
                  state_d = WDATA;
                end else if (DUMMY_CYCLES == 0) begin
                  state_d = RDATA;
                end else begin
                  state_d = DUMMY;
                end
              end
            end
            DUMMY: begin
              if (cnt_q == DUMMY_LAST) begin
                state_d = RDATA;
                cnt_d   = 8'd0;
              end
            end
            WDATA: begin
              if (cnt_q == data_last) begin
                state_d = GAP;
                cnt_d   = 8'd0;
              end
            end
            RDATA: begin
              rbuf_d[{dat_nib, 2'b00} +: 4] = sd_i;
              if (cnt_q == data_last) begin
                state_d = GAP;
                cnt_d   = 8'd0;
              end
            end
            default: begin
              // GAP: after CS_GAP full SCK periods with CS high, the slot that
              // would be the next H edge instead parks SCK low in IDLE.
              if (cnt_q == GAP_LAST) begin
                state_d     = IDLE;
                sck_d       = 1'b0;
                cnt_d       = 8'd0;
                rdy_d       = 1'b1;
                init_done_d = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= UNLOCK;
      phase_q     <= 1'b0;
      cnt_q       <= 8'd0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      sd_q        <= 4'b0000;
      sd_oe_q     <= 4'b0000;
      rdy_q       <= 1'b0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      rdat_q      <= 32'd0;
      rbuf_q      <= 32'd0;
      we_q        <= 1'b0;
      adr_q       <= 24'd0;
      size_q      <= 2'd0;
      wdat_q      <= 32'd0;
      xact_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      sd_q        <= sd_d;
      sd_oe_q     <= sd_oe_d;
      rdy_q       <= rdy_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      rdat_q      <= rdat_d;
      rbuf_q      <= rbuf_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      size_q      <= size_d;
      wdat_q      <= wdat_d;
      xact_q      <= xact_d;
    end
  end

  assign bus.rdy_o   = rdy_q;
  assign bus.ack_o   = ack_q;
  assign bus.rdat_o  = rdat_q;
  assign init_done_o = init_done_q;
  assign sck_o       = sck_q;
  assign cs_on       = cs_n_q;
  assign sd_o        = sd_q;
  assign sd_oe_o     = sd_oe_q;

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// tb/tb_qspi_psram_ctrl.sv - directed self-checking bench for qspi_psram_ctrl with a QSPI PSRAM model
module tb_qspi_psram_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_in = 1'b0;
  logic       init_done_o;
  logic       sck_o;
  logic       cs_on;
  logic [3:0] sd_o;
  logic [3:0] sd_oe_o;
  logic [3:0] sd_i = 4'h0;

  qspi_psram_ctrl_if bus_if ();

  qspi_psram_ctrl #(.DUMMY_CYCLES(6), .CS_GAP(1)) dut (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .bus         (bus_if),
    .init_done_o (init_done_o),
    .sck_o       (sck_o),
    .cs_on       (cs_on),
    .sd_o        (sd_o),
    .sd_oe_o     (sd_oe_o),
    .sd_i        (sd_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int ack_cnt  = 0;

  always @(posedge clk_i) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus_if.ack_o) ack_cnt <= ack_cnt + 1;
  end

  // PSRAM model
  logic [7:0]  mem [0:255];
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_adr = 24'h0;
  logic [31:0] m_wtrace = 32'h0;
  logic [3:0]  m_oe_or = 4'h0;
  logic [7:0]  m_last_cmd = 8'h00;
  int          m_cyc = 0;
  int          m_last_cyc = 0;
  int          m_unlocks = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge sck_o or posedge cs_on) begin : model_rx
    int j;
    logic [7:0] idx;
    if (cs_on) begin
      if (m_cyc > 0) begin
        m_last_cmd = m_cmd;
        m_last_cyc = m_cyc;
        if (m_cmd == 8'h35 && m_cyc == 8) m_unlocks++;
      end
      m_cyc = 0;
    end else begin
      if (m_cyc < 8) begin
        m_cmd = {m_cmd[6:0], sd_o[0]};
      end else if (m_cyc < 14) begin
        m_adr = {m_adr[19:0], sd_o};
      end else if (m_cmd == 8'h38) begin
        j = m_cyc - 14;
        idx = m_adr[7:0] + 8'(j / 2);
        if (j % 2 == 0) mem[idx][7:4] = sd_o;
        else            mem[idx][3:0] = sd_o;
        m_wtrace = {m_wtrace[27:0], sd_o};
      end else if (m_cmd == 8'hEB) begin
        m_oe_or = m_oe_or | sd_oe_o;
      end
      m_cyc++;
    end
  end

  always @(negedge sck_o) begin : model_tx
    int k;
    logic [7:0] ridx;
    if (!cs_on && m_cmd == 8'hEB && m_cyc >= 20) begin
      k = m_cyc - 20;
      ridx = m_adr[7:0] + 8'(k / 2);
      sd_i = (k % 2 == 0) ? mem[ridx][7:4] : mem[ridx][3:0];
    end else begin
      sd_i = 4'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!bus_if.rdy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(bus_if.rdy_o), 32'd1);
  endtask

  task automatic do_xact(input logic we, input logic [23:0] adr, input logic [1:0] size,
                         input logic [31:0] wdat, output int lat, output int rdy_lat);
    int a;
    int e;
    int n;
    lat = -1;
    rdy_lat = -1;
    wait_rdy("pre_rdy");
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = we;
    bus_if.adr_i  = adr;
    bus_if.size_i = size;
    bus_if.wdat_i = wdat;
    @(negedge clk_i);
    a = cyc_cnt;
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = ~we;
    bus_if.adr_i  = 24'hFFFFFF;
    bus_if.size_i = 2'd0;
    bus_if.wdat_i = 32'h0;
    n = 0;
    while (!bus_if.ack_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus_if.ack_o) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else begin
      e = cyc_cnt;
      lat = e - a;
      n = 0;
      while (!bus_if.rdy_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      rdy_lat = cyc_cnt - e;
    end
  endtask

  initial begin : stim
    int lat;
    int rl;
    int n;
    int run;
    int gap;
    int acb;
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = 1'b0;
    bus_if.adr_i  = 24'h0;
    bus_if.size_i = 2'd0;
    bus_if.wdat_i = 32'h0;

    #23;
    check("rst_cs", 32'(cs_on), 32'd1);
    check("rst_sck", 32'(sck_o), 32'd0);
    check("rst_oe", 32'(sd_oe_o), 32'd0);
    check("rst_rdy", 32'(bus_if.rdy_o), 32'd0);
    check("rst_init", 32'(init_done_o), 32'd0);
    check("rst_rdat", bus_if.rdat_o, 32'd0);
    @(negedge clk_i);
    rst_in = 1'b1;

    wait_rdy("init_rdy");
    check("unlock_cnt", 32'(m_unlocks), 32'd1);
    check("unlock_cmd", 32'(m_last_cmd), 32'h35);
    check("unlock_len", 32'(m_last_cyc), 32'd8);
    check("init_done", 32'(init_done_o), 32'd1);
    check("init_noack", 32'(ack_cnt), 32'd0);

    do_xact(1'b1, 24'h000010, 2'd2, 32'hDEADBEEF, lat, rl);
    check("wr4_lat", 32'(lat), 32'd45);
    check("wr4_rdy_lat", 32'(rl), 32'd3);
    check("wr4_cmd", 32'(m_last_cmd), 32'h38);
    check("wr4_adr", 32'(m_adr), 32'h000010);
    check("wr4_nibbles", m_wtrace, 32'hEFBEADDE);
    check("wr4_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

    m_oe_or = 4'h0;
    do_xact(1'b0, 24'h000010, 2'd2, 32'h0, lat, rl);
    check("rd4_lat", 32'(lat), 32'd57);
    check("rd4_data", bus_if.rdat_o, 32'hDEADBEEF);
    check("rd4_oe_off", 32'(m_oe_or), 32'd0);
    check("rd4_cmd", 32'(m_last_cmd), 32'hEB);

    do_xact(1'b0, 24'h000011, 2'd0, 32'h0, lat, rl);
    check("rd1_lat", 32'(lat), 32'd45);
    check("rd1_data", bus_if.rdat_o, 32'h000000BE);

    do_xact(1'b1, 24'h000020, 2'd1, 32'hFFFF1234, lat, rl);
    check("wr2_lat", 32'(lat), 32'd37);
    check("wr2_mem", {8'h00, mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h00001234);
    check("wr2_rdat_hold", bus_if.rdat_o, 32'h000000BE);

    do_xact(1'b0, 24'h000012, 2'd1, 32'h0, lat, rl);
    check("rd2_lat", 32'(lat), 32'd49);
    check("rd2_data", bus_if.rdat_o, 32'h0000DEAD);

    // Two reads with req held continuously.
    wait_rdy("hold_rdy");
    acb = ack_cnt;
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.adr_i  = 24'h000010;
    bus_if.size_i = 2'd2;
    n = 0;
    run = 0;
    gap = 0;
    while (ack_cnt - acb < 2 && n < 400) begin
      @(negedge clk_i);
      n++;
      if (ack_cnt - acb == 1) begin
        if (cs_on) run++;
        else if (run > 0 && gap == 0) gap = run;
      end
    end
    bus_if.req_i = 1'b0;
    check("hold_cs_gap", 32'(gap >= 2), 32'd1);
    repeat (100) @(negedge clk_i);
    check("hold_acks", 32'(ack_cnt - acb), 32'd2);
    check("hold_data", bus_if.rdat_o, 32'hDEADBEEF);

    // Reset in the middle of a read's data phase.
    wait_rdy("rst_pre_rdy");
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.adr_i  = 24'h000010;
    bus_if.size_i = 2'd2;
    @(negedge clk_i);
    bus_if.req_i = 1'b0;
    n = 0;
    while (m_cyc < 22 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_rdata", 32'(cs_on), 32'd0);
    acb = ack_cnt;
    #1;
    rst_in = 1'b0;
    #1;
    check("async_cs", 32'(cs_on), 32'd1);
    check("async_oe", 32'(sd_oe_o), 32'd0);
    check("async_rdy", 32'(bus_if.rdy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_in = 1'b1;
    wait_rdy("rst_post_rdy");
    check("rst_noack", 32'(ack_cnt - acb), 32'd0);
    check("rst_unlocks", 32'(m_unlocks), 32'd2);
    check("rst_unlock_cmd", 32'(m_last_cmd), 32'h35);
    do_xact(1'b0, 24'h000010, 2'd2, 32'h0, lat, rl);
    check("rst_rd_lat", 32'(lat), 32'd57);
    check("rst_rd_data", bus_if.rdat_o, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_psram_ctrl.md
Name: qspi_psram_ctrl

Overview:
Host-side QSPI PSRAM controller that sequences the external PSRAM for the core's memory bus.
- After reset it issues the Quad Mode Enable command (0x35).
- It then serves single bus requests as QSPI write (0x38) or QSPI fast read (0xEB, 6 dummy cycles) transactions of 1, 2 or 4 bytes.
- It sits between the bus/arbiter and the PSRAM pins and generates SCK at clk/2.

Parameters:
DUMMY_CYCLES, 6, read dummy SPI cycles between address and data
CS_GAP, 1, SPI cycles with cs_on high and SCK still toggling after each transaction (minimum 1)

Ports:
clk_i  in  1  system clock, single clock domain
rst_in  in  1  asynchronous active-low reset
req_i  in  1  request valid; accepted on the rising edge where req_i & rdy_o
rdy_o  out  1  controller idle and unlocked, ready to accept
we_i  in  1  1 = write, 0 = read
adr_i  in  24  PSRAM byte address
size_i  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
wdat_i  in  32  write data, little-endian, byte at adr_i in [7:0]
rdat_o  out  32  read data, little-endian, unused upper bytes zero
ack_o  out  1  one-cycle pulse on transaction completion; rdat_o valid in that cycle
init_done_o  out  1  unlock sequence completed
sck_o  out  1  serial clock
cs_on  out  1  active-low chip select
sd_o  out  4  io3..io0 output data
sd_oe_o  out  4  io3..io0 output enables
sd_i  in  4  io3..io0 input data

Behaviour:
- Reset values (async): sck_o=0, cs_on=1, sd_oe_o=0, sd_o=0, rdy_o=0, ack_o=0, init_done_o=0, rdat_o=0, state=UNLOCK.
- SPI cycle = 2 clk cycles:
  - Phase L edge: sck_o<=0; cs_on, sd_o and sd_oe_o update.
  - Phase H edge: sck_o<=1; sd_i is sampled on this same clk edge.
- SCK toggles continuously in every state except IDLE, where sck_o stays 0.
- Inputs adr_i, we_i, size_i and wdat_i are registered at acceptance and need not be held afterwards.
- State UNLOCK: 8 SPI cycles with cs_on=0, sending 0x35 MSB-first on sd_o[0]; sd_oe_o=0001. Then GAP; then init_done_o=1 and IDLE.
- State IDLE: rdy_o=1. On acceptance go to CMD; rdy_o=0 from the next cycle.
- State CMD: 8 SPI cycles, single-bit on sd_o[0], MSB first; command is 0x38 for write, 0xEB for read; sd_oe_o=0001.
- State ADR: 6 SPI cycles, quad, address nibbles adr[23:20] first; sd_oe_o=1111. Next state is WDATA for writes, DUMMY for reads.
- State DUMMY: DUMMY_CYCLES SPI cycles with sd_oe_o=0000 (turnaround).
- State WDATA: 2N SPI cycles, where N = byte count; byte 0 first, high nibble before low nibble; sd_oe_o=1111.
- State RDATA: 2N SPI cycles with sd_oe_o=0000; nibbles are sampled at phase H and assembled high nibble first into rdat_o byte k.
- End of transaction: on the phase L edge after the last data cycle, cs_on<=1, sd_oe_o<=0 and ack_o<=1 for one clk. Then state GAP.
- State GAP: CS_GAP SPI cycles with cs_on=1 and SCK toggling, then IDLE.
- Latency from accepting edge to the edge raising ack_o:
  - Read: 1+2*(14+DUMMY_CYCLES+2N); 57 clk for 4 bytes.
  - Write: 1+2*(14+2N); 45 clk for 4 bytes.
  - rdy_o returns 2*CS_GAP+1 clk after ack_o.
- req_i is ignored while rdy_o=0; requests are never queued.
- The address counter is not tracked; crossing 0xFFFFFF is left to the device.
- Reset mid-transaction: outputs return to reset values immediately (cs_on=1 asynchronously), the in-flight request is dropped with no ack_o, and the full UNLOCK sequence is repeated.
- rdat_o holds its value until the next read's ack_o.

Test Plan:
- Release reset with the PSRAM model attached -> 8 SPI cycles with cs low send 0x35; init_done_o=1 and rdy_o=1 after the GAP; no ack_o.
- Write adr=0x000010, size=2, wdat=0xDEADBEEF -> sd_o stream: cmd 0x38, nibbles 0,0,0,0,1,0, then E,F,B,E,A,D,D,E; ack_o 45 clk after acceptance; model mem[0x10..0x13] = EF,BE,AD,DE.
- Read back adr=0x000010, size=2 -> 6 dummy cycles with oe=0; ack_o 57 clk after acceptance; rdat_o=0xDEADBEEF.
- Read adr=0x000011, size=0 -> rdat_o=0x000000BE; ack_o 1+2*(20+2)=45 clk after acceptance.
- Hold req_i high continuously for two reads -> second read accepted only when rdy_o returns; exactly two ack_o pulses; cs_on high for at least one full SCK period between them.
- Assert rst_in during RDATA -> cs_on goes high without waiting for clk; no ack_o; unlock (0x35) reissued; a subsequent read returns correct data.
